// File: rtl/onehot_enc_fifo.sv
// One-hot match vector encoder feeding a small FIFO of {none, idx} entries.
// Multi-hot vectors are consumed without being queued and tallied in a saturating error counter.
module onehot_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_idx,
    output logic                     out_none,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_sticky,
    output logic [CW-1:0]            err_cnt,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] ERR_ONE = 1;

    logic [2:0]    mem_q [DEPTH];
    logic [2:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_sticky_q, err_sticky_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    logic [1:0] enc_idx;
    logic       enc_none;
    logic       enc_multi;
    logic       wr_fire;
    logic       legal_wr;
    logic       rd_fire;

    always_comb begin
        enc_idx   = '0;
        enc_none  = 1'b0;
        enc_multi = 1'b0;
        case (in_z)
            4'b0000: enc_none = 1'b1;
            4'b0001: enc_idx  = 2'd0;
            4'b0010: enc_idx  = 2'd1;
            4'b0100: enc_idx  = 2'd2;
            4'b1000: enc_idx  = 2'd3;
            default: enc_multi = 1'b1;
        endcase
    end

    // Handshake flags come from registered occupancy only, so a full FIFO never passes through.
    always_comb begin
        in_ready  = (count_q != FULL);
        out_valid = (count_q != '0);
        wr_fire   = in_valid & in_ready;
        legal_wr  = wr_fire & ~enc_multi;
        rd_fire   = out_valid & out_ready;
        out_idx   = mem_q[rd_ptr_q][1:0];
        out_none  = mem_q[rd_ptr_q][2];
        count      = count_q;
        err_sticky = err_sticky_q;
        err_cnt    = err_cnt_q;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (legal_wr) begin
            mem_d[wr_ptr_q] = {enc_none, enc_idx};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({legal_wr, rd_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // A clear in the same cycle as a multi-hot transfer wins; that vector is not counted.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end else if (wr_fire && enc_multi) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_onehot_enc_fifo.sv
// Randomised and directed bench for onehot_enc_fifo with a queue-based reference model.
module tb_onehot_enc_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_z;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_idx;
    logic            out_none;
    logic [CNTW-1:0] count;
    logic            err_sticky;
    logic [CW-1:0]   err_cnt;
    logic            err_clr;

    onehot_enc_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_none(out_none),
        .count(count),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected {none, idx} entries, error tally, and acceptance for the next edge.
    logic [2:0] exp_q[$];
    int         m_err_cnt    = 0;
    logic       m_err_sticky = 1'b0;
    logic       acc_ok       = 1'b1;
    int         err_max      = (1 << CW) - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {multi, none, idx[1:0]} from counting set bits
    function automatic logic [3:0] ref_enc(input logic [3:0] z);
        int   ones = 0;
        int   pos  = 0;
        for (int i = 0; i < 4; i++) begin
            if (z[i]) begin
                ones++;
                pos = i;
            end
        end
        return {ones > 1, ones == 0, 2'(pos)};
    endfunction

    // Scoreboard push: accepted stimulus at the clock edge.
    always @(posedge clk) begin
        logic [3:0] m;
        if (!rst) begin
            m = ref_enc(in_z);
            if (in_valid && acc_ok && !m[3]) exp_q.push_back(m[2:0]);
            if (err_clr) begin
                m_err_cnt    = 0;
                m_err_sticky = 1'b0;
            end else if (in_valid && acc_ok && m[3]) begin
                m_err_sticky = 1'b1;
                if (m_err_cnt != err_max) m_err_cnt++;
            end
        end
    end

    // Monitor: compare visible state on the falling edge, pop on an output transfer.
    always @(negedge clk) begin
        int n;
        n = exp_q.size();
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(n != 0));
        if (n != 0) begin
            chk("out_idx", 32'(out_idx), 32'(exp_q[0][1:0]));
            chk("out_none", 32'(out_none), 32'(exp_q[0][2]));
        end else if (rst) begin
            chk("rst_out_idx", 32'(out_idx), 32'd0);
            chk("rst_out_none", 32'(out_none), 32'd0);
        end
        chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        chk("err_sticky", 32'(err_sticky), 32'(m_err_sticky));
        acc_ok = (n != DEPTH);
        if (n != 0 && out_ready) void'(exp_q.pop_front());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] z, input logic r);
        int n = 0;
        in_valid  = 1'b1;
        in_z      = z;
        out_ready = r;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout z=%b in_ready=%b required=1", z, in_ready);
        end
        step();
        in_valid = 1'b0;
        in_z     = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (out_valid) begin
            failures++;
            $display("FAIL drain_timeout out_valid=%b required=0", out_valid);
        end
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        logic [3:0] pat [4];
        logic [3:0] z;
        pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100; pat[3] = 4'b1000;

        rst = 1'b1; in_valid = 1'b0; in_z = '0; out_ready = 1'b0; err_clr = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Each legal code, fifth write stalls on full until a read frees a slot.
        for (int i = 0; i < 4; i++) send(pat[i], 1'b0);
        send(4'b0000, 1'b1);
        out_ready = 1'b0;
        drain();

        // Full, then read-with-write attempt: only the read happens.
        for (int i = 0; i < 4; i++) send(pat[i], 1'b0);
        in_valid = 1'b1; in_z = 4'b0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("full_rd_count", 32'(count), 32'd3);
        chk("full_rd_ready", 32'(in_ready), 32'd1);
        drain();

        // Streaming with pointer wrap.
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_z = pat[i % 4]; out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0;
        drain();

        // Multi-hot drops between legal vectors.
        send(4'b0100, 1'b0);
        send(4'b0011, 1'b0);
        send(4'b1111, 1'b0);
        send(4'b1000, 1'b0);
        chk("drop_count", 32'(count), 32'd2);
        chk("drop_err_cnt", 32'(err_cnt), 32'd2);
        drain();

        // Saturation, then a clear coinciding with a multi-hot transfer.
        for (int i = 0; i < 5; i++) send(4'b0110, 1'b0);
        chk("sat_err_cnt", 32'(err_cnt), 32'(err_max));
        in_valid = 1'b1; in_z = 4'b1100; err_clr = 1'b1;
        step();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_err_sticky", 32'(err_sticky), 32'd0);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) send(pat[i], 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        m_err_cnt = 0; m_err_sticky = 1'b0; acc_ok = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        send(4'b1000, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_idx", 32'(out_idx), 32'd3);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       z = 4'($urandom);
                1:       z = 4'b0000;
                default: z = pat[$urandom_range(0, 3)];
            endcase
            in_valid  = 1'($urandom_range(0, 1));
            in_z      = z;
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
            step();
        end
        err_clr = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
